dac_out: RTL

- Output-side counterpart of the ADC input path.
- Takes a signed Q16.48 voltage word from the SPGD core and scales it to a DAC code, saturating at both rails.
- Serialises the code in a 24-bit SPI-style frame (SYNC_N/SCLK/DIN) to one channel of an external multi-channel DAC.
- Upstream sees a valid/ready handshake and a DONE pulse, so it can step actuator channels sequentially.

---
 rtl/dac_pkg.sv | 28 ++
 rtl/dac_out_if.sv | 22 ++
 rtl/dac_fp_to_code.sv | 45 ++++
 rtl/dac_out.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared constants, FSM state codes and command helpers for the DAC output path
//
// Contents:
//   FRAME_BITS, CMD_W, CH_W : serial frame layout {cmd, channel, 16-bit data}
//   CMD_WRITE_UPDATE        : write input register and update output
//   CMD_WRITE_INPUT         : write input register only (output moves on LDAC)
//   ST_*                    : dac_out FSM state codes
//   input_only_cmd()        : clears the "update" bit of a command nibble
package dac_pkg;

  localparam int FRAME_BITS = 24;
  localparam int CMD_W      = 4;
  localparam int CH_W       = 4;

  localparam logic [CMD_W-1:0] CMD_WRITE_UPDATE = 4'h3;
  localparam logic [CMD_W-1:0] CMD_WRITE_INPUT  = 4'h2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CONV  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_LDAC  = 3'd4;

  function automatic logic [CMD_W-1:0] input_only_cmd(input logic [CMD_W-1:0] cmd);
    return {cmd[CMD_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/dac_out_if.sv
// rtl/dac_out_if.sv - upstream word handshake into the DAC output path
//
// Signals:
//   in_valid : FP_DATA and CH are valid
//   in_ready : block can accept a word
//   FP_DATA  : signed fixed-point voltage word (FP_WIDTH bits)
//   CH       : DAC channel address
// Modports: master (SPGD core side), slave (dac_out side).
interface dac_out_if #(
  parameter int FP_WIDTH = 64
);
  import dac_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [FP_WIDTH-1:0] FP_DATA;
  logic [CH_W-1:0]     CH;

  modport master (output in_valid, FP_DATA, CH, input in_ready);
  modport slave  (input in_valid, FP_DATA, CH, output in_ready);

endinterface

// File: rtl/dac_fp_to_code.sv
// rtl/dac_fp_to_code.sv - combinational fixed-point voltage to saturated DAC code
//
// Ports:
//   fp_data : signed fixed-point voltage, INT_WIDTH integer bits
//   code    : DAC code, clamped to 0 .. 2^DAC_WIDTH-1
//   sat     : code was clamped at either rail
module dac_fp_to_code #(
  parameter int          FP_WIDTH      = 64,
  parameter int          INT_WIDTH     = 16,
  parameter int          DAC_WIDTH     = 12,
  parameter int unsigned CODE_PER_VOLT = 819
) (
  input  logic [FP_WIDTH-1:0]  fp_data,
  output logic [DAC_WIDTH-1:0] code,
  output logic                 sat
);

  // 32 extra bits hold the full product of the word and a 32-bit gain.
  localparam int PW   = FP_WIDTH + 32;
  localparam int FRAC = FP_WIDTH - INT_WIDTH;

  localparam logic signed [PW-1:0] GAIN     = $signed(PW'(CODE_PER_VOLT));
  localparam logic signed [PW-1:0] MAX_CODE = $signed(PW'((64'd1 << DAC_WIDTH) - 64'd1));

  logic signed [PW-1:0] fp_ext;
  logic signed [PW-1:0] product;
  logic signed [PW-1:0] raw;

  always_comb begin
    fp_ext  = {{(PW-FP_WIDTH){fp_data[FP_WIDTH-1]}}, fp_data};
    product = fp_ext * GAIN;
    // Arithmetic shift floors toward -inf, so any negative voltage clamps to 0.
    raw     = product >>> FRAC;
    code    = raw[DAC_WIDTH-1:0];
    sat     = 1'b0;
    if (raw[PW-1]) begin
      code = '0;
      sat  = 1'b1;
    end else if (raw > MAX_CODE) begin
      code = '1;
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/dac_out.sv
// rtl/dac_out.sv - scales a fixed-point voltage to a DAC code and shifts it out as a 24-bit SPI frame
//
// Ports:
//   CLK, RST  : system clock, synchronous active-high reset
//   up        : dac_out_if.slave word handshake (in_valid/in_ready/FP_DATA/CH)
//   DONE      : one-cycle pulse when a frame completes
//   SAT       : last accepted word was clamped
//   LAST_CODE : code of the last frame
//   SYNC_N    : frame select, active low
//   SCLK      : serial clock, idles low
//   DIN       : serial data, MSB first, changes as SCLK falls
//   LDAC_N    : load-DAC strobe, active low (only with DAC_OUT_LDAC_EN)
// Build option: DAC_OUT_LDAC_EN sends write-input-only commands and pulses
// LDAC_N for CLK_DIV cycles after the inter-frame gap.
module dac_out
  import dac_pkg::*;
#(
  parameter int          FP_WIDTH      = 64,
  parameter int          INT_WIDTH     = 16,
  parameter int          DAC_WIDTH     = 12,
  parameter int unsigned CODE_PER_VOLT = 819,
  parameter int          CLK_DIV       = 4,
  parameter logic [CMD_W-1:0] CMD      = CMD_WRITE_UPDATE
) (
  input  logic                 CLK,
  input  logic                 RST,
  dac_out_if.slave             up,
  output logic                 DONE,
  output logic                 SAT,
  output logic [DAC_WIDTH-1:0] LAST_CODE,
  output logic                 SYNC_N,
  output logic                 SCLK,
`ifdef DAC_OUT_LDAC_EN
  output logic                 LDAC_N,
`endif
  output logic                 DIN
);

`ifdef DAC_OUT_LDAC_EN
  localparam logic [CMD_W-1:0] CMD_TX = input_only_cmd(CMD);
`else
  localparam logic [CMD_W-1:0] CMD_TX = CMD;
`endif

  localparam int            DW       = $clog2(2 * CLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_LAST = DW'(2 * CLK_DIV - 1);

  logic [2:0]            state;
  logic [FP_WIDTH-1:0]   fp_q;
  logic [CH_W-1:0]       ch_q;
  logic [FRAME_BITS-1:0] frame;
  logic [DW-1:0]         div_cnt;
  logic [4:0]            bit_cnt;
  logic [DAC_WIDTH-1:0]  code_c;
  logic                  sat_c;

  dac_fp_to_code #(
    .FP_WIDTH     (FP_WIDTH),
    .INT_WIDTH    (INT_WIDTH),
    .DAC_WIDTH    (DAC_WIDTH),
    .CODE_PER_VOLT(CODE_PER_VOLT)
  ) u_conv (
    .fp_data(fp_q),
    .code   (code_c),
    .sat    (sat_c)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      up.in_ready <= 1'b1;
      DONE        <= 1'b0;
      SAT         <= 1'b0;
      LAST_CODE   <= '0;
      SYNC_N      <= 1'b1;
      SCLK        <= 1'b0;
      DIN         <= 1'b0;
      fp_q        <= '0;
      ch_q        <= '0;
      frame       <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
`ifdef DAC_OUT_LDAC_EN
      LDAC_N      <= 1'b1;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (up.in_valid && up.in_ready) begin
            fp_q        <= up.FP_DATA;
            ch_q        <= up.CH;
            up.in_ready <= 1'b0;
            state       <= ST_CONV;
          end
        end
        ST_CONV: begin
          LAST_CODE <= code_c;
          SAT       <= sat_c;
          frame     <= {CMD_TX, ch_q, 16'(code_c) << (16 - DAC_WIDTH)};
          state     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // First SHIFT cycle only opens the frame: SYNC_N still high marks it.
          if (SYNC_N) begin
            SYNC_N  <= 1'b0;
            DIN     <= frame[FRAME_BITS-1];
            bit_cnt <= 5'(FRAME_BITS - 1);
            div_cnt <= '0;
          end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!SCLK) begin
              SCLK <= 1'b1;
            end else begin
              SCLK <= 1'b0;
              if (bit_cnt == 5'd0) begin
                SYNC_N <= 1'b1;
                DIN    <= 1'b0;
                state  <= ST_GAP;
              end else begin
                bit_cnt <= bit_cnt - 5'd1;
                DIN     <= frame[bit_cnt-5'd1];
              end
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        ST_GAP: begin
          if (div_cnt == GAP_LAST) begin
            div_cnt <= '0;
`ifdef DAC_OUT_LDAC_EN
            LDAC_N  <= 1'b0;
            state   <= ST_LDAC;
`else
            DONE        <= 1'b1;
            up.in_ready <= 1'b1;
            state       <= ST_IDLE;
`endif
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
`ifdef DAC_OUT_LDAC_EN
        ST_LDAC: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt     <= '0;
            LDAC_N      <= 1'b1;
            DONE        <= 1'b1;
            up.in_ready <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
`endif
        default: begin
          state       <= ST_IDLE;
          up.in_ready <= 1'b1;
          SYNC_N      <= 1'b1;
          SCLK        <= 1'b0;
          DIN         <= 1'b0;
          div_cnt     <= '0;
        end
      endcase
    end
  end

endmodule
